// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioning block.
// Latency: none (types and constant functions only); backpressure: none.
package key_pkg;

    typedef enum logic [2:0] {
        K_IDLE,
        K_DB_PRESS,
        K_HOLD,
        K_REPEAT,
        K_DB_RELEASE
    } key_state_t;

    // Width needed for one counter that must be able to hold the largest timing value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
// Latency: 2 clk edges; backpressure: none.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_pulser.sv
// Debounces an active-low key into single-cycle step pulses with optional auto-repeat.
// Latency: DEBOUNCE_CYCLES+2 edges from stable press to pulse/held; backpressure: none.
module key_pulser
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic Re_n,
    input  logic key_n,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    // The hold delay is compared one count later so the first repeat lands
    // REPEAT_DELAY+1 edges after the initial pulse.
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    key_state_t     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt, cnt_inc;
    logic           pulse_nxt, held_nxt;
    logic           key_sync, pr;

    sync2 #(.RST_VAL(1'b1)) u_key_sync (
        .clk   (clk),
        .rst_n (Re_n),
        .d     (key_n),
        .q     (key_sync)
    );

    assign pr      = ~key_sync;
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        pulse_nxt = 1'b0;
        case (state)
            K_IDLE: begin
                cnt_nxt = '0;
                if (pr) state_nxt = K_DB_PRESS;
            end
            K_DB_PRESS: begin
                if (!pr) begin
                    state_nxt = K_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = K_HOLD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            K_HOLD: begin
                if (!pr) begin
                    state_nxt = K_DB_RELEASE;
                    cnt_nxt   = '0;
                end else if (repeat_en && cnt == DLY_LAST) begin
                    state_nxt = K_REPEAT;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            K_REPEAT: begin
                if (!pr) begin
                    state_nxt = K_DB_RELEASE;
                    cnt_nxt   = '0;
                end else if (!repeat_en) begin
                    state_nxt = K_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == PER_LAST) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            K_DB_RELEASE: begin
                if (pr) begin
                    state_nxt = K_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = K_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = K_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        held_nxt = (state_nxt == K_HOLD) || (state_nxt == K_REPEAT) ||
                   (state_nxt == K_DB_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (!Re_n) begin
            state <= K_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            held  <= held_nxt;
        end
    end

endmodule

// File: tb/tb_key_pulser.sv
// Bench for key_pulser: reset/press/release table, hand-built corner sequences,
// then random key traffic compared edge by edge against a run-length model.
module tb_key_pulser;

    localparam int D = 4;
    localparam int R = 10;
    localparam int P = 3;

    logic clk = 1'b0;
    logic Re_n = 1'b0;
    logic key_n = 1'b1;
    logic repeat_en = 1'b0;
    logic pulse, held;

    always #5 clk = ~clk;

    key_pulser #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (R),
        .REPEAT_PERIOD   (P)
    ) dut (
        .clk       (clk),
        .Re_n      (Re_n),
        .key_n     (key_n),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .held      (held)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: raw samples pass through two stages of history, then the
    // debounced level flips after D+1 consecutive disagreeing samples; while the
    // level is pressed, t counts edges since the hold (re)started or the last pulse.
    bit m_h1 = 1'b1, m_h2 = 1'b1;
    bit m_level = 1'b0, m_pulse = 1'b0, m_rep = 1'b0;
    int m_run = 0, m_t = 0;

    typedef struct {
        logic re;
        logic key;
        logic en;
        logic p;
        logic h;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit pr;
        if (!Re_n) begin
            m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b0; m_pulse = 1'b0;
            m_run = 0; m_t = 0; m_rep = 1'b0;
            return;
        end
        pr = !m_h2;
        m_h2 = m_h1;
        m_h1 = key_n;
        m_pulse = 1'b0;
        if (!m_level) begin
            m_run = pr ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_level = 1'b1; m_pulse = 1'b1; m_run = 0; m_t = 0; m_rep = 1'b0;
            end
        end else if (!pr) begin
            m_run++; m_t = 0; m_rep = 1'b0;
            if (m_run == D + 1) begin
                m_level = 1'b0; m_run = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0; m_t = 0; m_rep = 1'b0;
        end else begin
            m_t++;
            if (!m_rep) begin
                if (repeat_en && m_t == R + 1) begin
                    m_pulse = 1'b1; m_rep = 1'b1; m_t = 0;
                end
            end else if (!repeat_en) begin
                m_rep = 1'b0; m_t = 0;
            end else if (m_t == P) begin
                m_pulse = 1'b1; m_t = 0;
            end
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sees, then compare.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("model_pulse", pulse, m_pulse);
        check("model_held", held, m_held_bit());
    endtask

    function automatic logic m_held_bit();
        return m_level;
    endfunction

    task automatic do_reset();
        Re_n = 1'b0; key_n = 1'b1; repeat_en = 1'b0;
        tick(); tick();
        Re_n = 1'b1;
        tick(); tick(); tick();
    endtask

    function automatic vec_t v(input logic re, input logic key, input logic en,
                               input logic p, input logic h);
        vec_t x;
        x.re = re; x.key = key; x.en = en; x.p = p; x.h = h;
        return x;
    endfunction

    initial begin
        // Reset with key held, then release reset: press re-debounced from edge 2,
        // pulse/held at edge 8; key released at edge 10, held drops at edge 16.
        tv.push_back(v(0, 0, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 0, 0));
        tv.push_back(v(1, 0, 0, 1, 1));
        tv.push_back(v(1, 0, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 1));
        tv.push_back(v(1, 1, 0, 0, 0));

        foreach (tv[i]) begin
            Re_n = tv[i].re; key_n = tv[i].key; repeat_en = tv[i].en;
            tick();
            check($sformatf("table%0d_pulse", i), pulse, tv[i].p);
            check($sformatf("table%0d_held", i), held, tv[i].h);
        end

        // Single press without repeat: one pulse at edge 6, held until release+6.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            key_n = (i < 20) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("press_pulse@%0d", i), pulse, i == 6);
            check($sformatf("press_held@%0d", i), held, i >= 6 && i < 26);
        end

        // Bounce shorter than the debounce window never registers.
        do_reset();
        begin
            logic [14:0] bounce;
            bounce = 15'b111111111000100;
            for (int i = 0; i < 15; i++) begin
                key_n = bounce[i];
                tick();
                check($sformatf("bounce_pulse@%0d", i), pulse, 1'b0);
                check($sformatf("bounce_held@%0d", i), held, 1'b0);
            end
        end

        // Auto-repeat: pulses at 6, 17, then every 3 edges while the synchronized
        // key is still pressed (last such edge is 41 for a release sampled at 40).
        do_reset();
        repeat_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            key_n = (i < 40) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("repeat_pulse@%0d", i), pulse,
                  i == 6 || (i >= 17 && i <= 41 && (i - 17) % 3 == 0));
            check($sformatf("repeat_held@%0d", i), held, i >= 6 && i < 46);
        end

        // Two-cycle release glitch in hold: no pulse, held stays, delay restarts
        // so the first repeat moves from edge 17 to edge 23.
        do_reset();
        repeat_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            key_n = (i == 8 || i == 9) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("glitch_pulse@%0d", i), pulse,
                  i == 6 || (i >= 23 && (i - 23) % 3 == 0));
            check($sformatf("glitch_held@%0d", i), held, i >= 6);
        end

        // Reset during repeat with key still pressed: outputs clear, press re-debounced.
        do_reset();
        repeat_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            key_n = 1'b0;
            Re_n = (i == 19) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("rst_rep_pulse@%0d", i), pulse, i == 6 || i == 17 || i == 26);
            check($sformatf("rst_rep_held@%0d", i), held, (i >= 6 && i < 19) || i >= 26);
        end

        // Random key segments, bounces, repeat_en toggles and sporadic resets.
        do_reset();
        begin
            int seg;
            seg = 0;
            for (int i = 0; i < 4000; i++) begin
                if (seg == 0) begin
                    key_n = 1'($urandom_range(0, 1));
                    seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                       : $urandom_range(5, 45);
                end
                seg--;
                if ($urandom_range(0, 24) == 0) repeat_en = ~repeat_en;
                Re_n = ($urandom_range(0, 299) != 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
